// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin sharing of one DATA_LEN-bit adder between
// NUM_REQ valid/ready requesters, with a one-entry tagged result register.
// Optional build macro: SHARED_ADDER_CARRY_OUT_EN adds a registered resp_cout
// output carrying bit DATA_LEN of the full-width sum.

// Per-requester ready decode: a lane is ready only when it is the winner
// and the result register can take a new sum.
module shared_adder_arbiter_lane #(
    parameter int ID_W = 2,
    parameter int LANE = 0
) (
    input  logic            gnt_en,
    input  logic [ID_W-1:0] gnt_idx,
    output logic            ready
);
    assign ready = gnt_en && (gnt_idx == ID_W'(LANE));
endmodule

module shared_adder_arbiter #(
    parameter  int DATA_LEN = 32,
    parameter  int NUM_REQ  = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_op_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_LEN-1:0]         resp_sum,
`ifdef SHARED_ADDER_CARRY_OUT_EN
    output logic                        resp_cout,
`endif
    output logic [ID_W-1:0]             resp_id
);

    // Same bit layout as the flat buses, viewed per requester.
    logic [NUM_REQ-1:0][DATA_LEN-1:0] op_a;
    logic [NUM_REQ-1:0][DATA_LEN-1:0] op_b;
    assign op_a = req_op_a;
    assign op_b = req_op_b;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            any_valid;
    logic            can_accept;
    logic            gnt_en;

    assign any_valid  = |req_valid;
    // Pass-through: a new sum may load while the old one is being consumed.
    assign can_accept = !resp_valid || resp_ready;
    // Ready is forced low during reset so nothing is consumed on that edge.
    assign gnt_en     = any_valid && can_accept && !rst;

    // Round-robin search from ptr+1 upward with wrap; scanning the offsets
    // from farthest to nearest lets the nearest valid requester win last.
    always_comb begin
        gnt_idx = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ])
                gnt_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            shared_adder_arbiter_lane #(.ID_W(ID_W), .LANE(gi)) u_lane (
                .gnt_en  (gnt_en),
                .gnt_idx (gnt_idx),
                .ready   (req_ready[gi])
            );
        end
    endgenerate

`ifdef SHARED_ADDER_CARRY_OUT_EN
    logic [DATA_LEN:0] sum_full;
    assign sum_full = {1'b0, op_a[gnt_idx]} + {1'b0, op_b[gnt_idx]};

    // Carry-out register tracks the sum register exactly.
    always_ff @(posedge clk) begin
        if (rst)
            resp_cout <= 1'b0;
        else if (gnt_en)
            resp_cout <= sum_full[DATA_LEN];
    end
`else
    logic [DATA_LEN-1:0] sum_full;
    assign sum_full = op_a[gnt_idx] + op_b[gnt_idx];
`endif

    // Result register and last-grant pointer; reset parks ptr so requester 0
    // is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
            ptr        <= ID_W'(NUM_REQ - 1);
        end else if (gnt_en) begin
            resp_valid <= 1'b1;
            resp_sum   <= sum_full[DATA_LEN-1:0];
            resp_id    <= gnt_idx;
            ptr        <= gnt_idx;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (DATA_LEN=32, NUM_REQ=4).
module tb_shared_adder_arbiter;
    localparam int DL = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DL-1:0]  req_op_a;
    logic [NR*DL-1:0]  req_op_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [DL-1:0]     resp_sum;
    logic [1:0]        resp_id;
`ifdef SHARED_ADDER_CARRY_OUT_EN
    logic              resp_cout;
`endif

    int vecs = 0;
    int errs = 0;

    shared_adder_arbiter #(.DATA_LEN(DL), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
`ifdef SHARED_ADDER_CARRY_OUT_EN
        .resp_cout  (resp_cout),
`endif
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [DL-1:0] a, input logic [DL-1:0] b);
        req_op_a[i*DL +: DL] = a;
        req_op_b[i*DL +: DL] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
        tick(); tick();
        vecs++;
        if (req_ready !== 4'b0000) begin
            errs++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b0, 2'd0, 32'd0}) begin
            errs++; $display("FAIL reset_state: got v=%b id=%0d sum=%0h want v=0 id=0 sum=0",
                             resp_valid, resp_id, resp_sum);
        end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        set_ops(0, 32'd5, 32'd7);
        req_valid = 4'b0001; resp_ready = 1'b0;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd0, 32'd12}) begin
            errs++; $display("FAIL single_resp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=12",
                             resp_valid, resp_id, resp_sum);
        end
        resp_ready = 1'b1;
        tick();
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b0, 2'd0, 32'd12}) begin
            errs++; $display("FAIL single_drain: got v=%b id=%0d sum=%0d want v=0 id=0 sum=12",
                             resp_valid, resp_id, resp_sum);
        end
    endtask

    // ptr=0 here, so requester 1 is next in line.
    task automatic test_overflow();
        set_ops(1, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b0010; resp_ready = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 4'b0010) begin
            errs++; $display("FAIL ovf_ready: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd1, 32'd1}) begin
            errs++; $display("FAIL ovf_resp: got v=%b id=%0d sum=%0h want v=1 id=1 sum=1",
                             resp_valid, resp_id, resp_sum);
        end
`ifdef SHARED_ADDER_CARRY_OUT_EN
        vecs++;
        if (resp_cout !== 1'b1) begin
            errs++; $display("FAIL ovf_cout: got %b want 1", resp_cout);
        end
`endif
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NR; i++) set_ops(i, DL'(i), 32'd10);
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % NR);
            vecs++;
            if (req_ready !== exp_rdy) begin
                errs++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            vecs++;
            if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'(k % NR), 32'(10 + k % NR)}) begin
                errs++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                                 k, resp_valid, resp_id, resp_sum, k % NR, 10 + k % NR);
            end
        end
        req_valid = '0;
        tick();
    endtask

    // ptr=0 on entry; grant requester 3 (sum 13) then hold it under backpressure.
    task automatic test_backpressure();
        req_valid = 4'b1000; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++;
            if (req_ready !== 4'b0000) begin
                errs++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            @(posedge clk); #1;
            vecs++;
            if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd3, 32'd13}) begin
                errs++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d want v=1 id=3 sum=13",
                                 k, resp_valid, resp_id, resp_sum);
            end
        end
        resp_ready = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 4'b0010) begin
            errs++; $display("FAIL bp_release_ready: got %b want 0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd1, 32'd11}) begin
            errs++; $display("FAIL bp_release_resp: got v=%b id=%0d sum=%0d want v=1 id=1 sum=11",
                             resp_valid, resp_id, resp_sum);
        end
        tick();
    endtask

    // ptr=1 on entry.
    task automatic test_pointer_skip();
        req_valid = 4'b0100; resp_ready = 1'b1;
        tick();
        req_valid = 4'b0101;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++; $display("FAIL skip_wrap_ready: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd0, 32'd10}) begin
            errs++; $display("FAIL skip_wrap_resp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=10",
                             resp_valid, resp_id, resp_sum);
        end
        vecs++;
        if (req_ready !== 4'b0100) begin
            errs++; $display("FAIL skip_next_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd2, 32'd12}) begin
            errs++; $display("FAIL skip_next_resp: got v=%b id=%0d sum=%0d want v=1 id=2 sum=12",
                             resp_valid, resp_id, resp_sum);
        end
        tick();
    endtask

    // ptr=2; idle cycles must not move it, so the next grant goes to 3.
    task automatic test_no_request();
        req_valid = '0; resp_ready = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
            errs++; $display("FAIL idle: got ready=%b v=%b want ready=0000 v=0", req_ready, resp_valid);
        end
        tick(); tick();
        req_valid = 4'b1111;
        #1;
        vecs++;
        if (req_ready !== 4'b1000) begin
            errs++; $display("FAIL idle_ptr_hold: got %b want 1000", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    // ptr=3; grant 2 to set ptr=2 and leave a pending result, then reset.
    task automatic test_reset_mid();
        req_valid = 4'b0100; resp_ready = 1'b1;
        tick();
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        vecs++;
        if (req_ready !== 4'b0000) begin
            errs++; $display("FAIL rstmid_ready: got %b want 0000", req_ready);
        end
        @(posedge clk); #1;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b0, 2'd0, 32'd0}) begin
            errs++; $display("FAIL rstmid_state: got v=%b id=%0d sum=%0d want v=0 id=0 sum=0",
                             resp_valid, resp_id, resp_sum);
        end
`ifdef SHARED_ADDER_CARRY_OUT_EN
        vecs++;
        if (resp_cout !== 1'b0) begin
            errs++; $display("FAIL rstmid_cout: got %b want 0", resp_cout);
        end
`endif
        rst = 1'b0;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++; $display("FAIL rstmid_first_ready: got %b want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        vecs++;
        if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'd0, 32'd10}) begin
            errs++; $display("FAIL rstmid_first_resp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=10",
                             resp_valid, resp_id, resp_sum);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_op_a = '0; req_op_b = '0;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_no_request();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
